stopwatch_ctrl: RTL and testbench



---
 rtl/stopwatch_pkg.sv | 20 ++
 rtl/bcd_digit.sv | 46 ++++
 rtl/stopwatch_ctrl.sv | 114 +++++++++++
 tb/tb_stopwatch_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the stopwatch controller.
package stopwatch_pkg;

  localparam int unsigned StateW = 3;
  localparam int unsigned DigitW = 4;

  typedef enum logic [StateW-1:0] {
    StIdle     = 3'd0,
    StCounting = 3'd1,
    StStop     = 3'd2,
    StLap      = 3'd3,
    StDone     = 3'd4
  } state_e;

  // Nibbles above 9 are clamped to 9 so every decade is always a legal BCD digit.
  function automatic logic [DigitW-1:0] clamp_bcd(input logic [DigitW-1:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: loadable, up/down, with ripple carry/borrow and terminal flag.
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [DigitW-1:0] load_val_i,
  input  logic              en_i,
  input  logic              down_i,
  output logic [DigitW-1:0] q_o,
  output logic [DigitW-1:0] q_d_o,
  output logic              cout_o,
  output logic              term_o
);

  logic [DigitW-1:0] q_q, q_d;

  // Terminal is 9 when counting up, 0 when counting down.
  assign term_o = down_i ? (q_q == 4'd0) : (q_q == 4'd9);
  assign cout_o = en_i && term_o;
  assign q_o    = q_q;
  assign q_d_o  = q_d;

  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = clamp_bcd(load_val_i);
    end else if (en_i) begin
      if (down_i) begin
        q_d = term_o ? 4'd9 : q_q - 4'd1;
      end else begin
        q_d = term_o ? 4'd0 : q_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: start/pause/lap/clear FSM over a DIGITS-wide BCD up/down counter.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter bit          WRAP   = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pause_start,
  input  logic                     lap,
  input  logic                     clear,
  input  logic                     tick,
  input  logic                     mode_down,
  input  logic [DigitW*DIGITS-1:0] preset,
  output logic [StateW-1:0]        state,
  output logic [DigitW*DIGITS-1:0] count,
  output logic [DigitW*DIGITS-1:0] display,
  output logic                     done,
  output logic                     wrap
);

  localparam int unsigned W = DigitW * DIGITS;

  state_e         state_q;
  logic           mode_q;
  logic [W-1:0]   lap_q;
  logic           done_q, wrap_q;

  logic [W-1:0]   count_d;
  logic [W-1:0]   init_val;
  logic [DIGITS:0] en;
  logic [DIGITS-1:0] term;
  logic           running, tick_ok, up_term, down_hit, adv, load, start_ok;

  assign running  = (state_q == StCounting) || (state_q == StLap);
  assign tick_ok  = running && tick && !clear;
  assign up_term  = tick_ok && !mode_q && (&term);
  // The tick that takes the count from 1 to 0 ends a down run.
  assign down_hit = tick_ok && mode_q && (count == W'(1));
  assign adv      = tick_ok && !(up_term && !WRAP);
  assign load     = clear || (state_q == StIdle);
  assign init_val = mode_down ? preset : '0;
  assign start_ok = !(mode_down && (preset == '0));
  assign en[0]    = adv;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk        (clk),
      .rst        (rst),
      .load_i     (load),
      .load_val_i (init_val[DigitW*i +: DigitW]),
      .en_i       (en[i]),
      .down_i     (mode_q),
      .q_o        (count[DigitW*i +: DigitW]),
      .q_d_o      (count_d[DigitW*i +: DigitW]),
      .cout_o     (en[i+1]),
      .term_o     (term[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      mode_q  <= 1'b0;
      lap_q   <= '0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // A carry out of the top decade while counting up is the all-9s rollover.
      wrap_q <= en[DIGITS] && !mode_q;
      if (clear) begin
        state_q <= StIdle;
      end else begin
        case (state_q)
          StIdle: begin
            if (pause_start && start_ok) begin
              state_q <= StCounting;
              mode_q  <= mode_down;
            end
          end
          StCounting, StLap: begin
            if (down_hit || (up_term && !WRAP)) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else if (pause_start) begin
              state_q <= StStop;
            end else if (lap) begin
              if (state_q == StCounting) begin
                state_q <= StLap;
                lap_q   <= count_d;
              end else begin
                state_q <= StCounting;
              end
            end
          end
          StStop: begin
            if (pause_start) begin
              state_q <= StCounting;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign state   = state_q;
  assign display = (state_q == StLap) ? lap_q : count;
  assign done    = done_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: WRAP=1 and WRAP=0 instances driven in lockstep against a decimal model.
module tb_stopwatch_ctrl;

  localparam int D    = 4;
  localparam int W    = 4 * D;
  localparam int MAXV = 9999;

  logic clk = 1'b0;
  logic rst = 1'b1, ps = 1'b0, lp = 1'b0, clr = 1'b0, tk = 1'b0, md = 1'b0;
  logic [W-1:0] pre = '0;

  // Index 0: WRAP=1 instance, index 1: WRAP=0 instance.
  logic [2:0]   st_o  [2];
  logic [W-1:0] cnt_o [2];
  logic [W-1:0] dsp_o [2];
  logic         dn_o  [2];
  logic         wr_o  [2];

  int checks = 0;
  int errors = 0;

  int m_st [2], m_cnt [2], m_lap [2];
  bit m_mode [2], m_done [2], m_wrap [2];

  always #5 clk = ~clk;

  stopwatch_ctrl #(.DIGITS(D), .WRAP(1'b1)) u_w1 (
    .clk(clk), .rst(rst), .pause_start(ps), .lap(lp), .clear(clr), .tick(tk),
    .mode_down(md), .preset(pre), .state(st_o[0]), .count(cnt_o[0]),
    .display(dsp_o[0]), .done(dn_o[0]), .wrap(wr_o[0])
  );

  stopwatch_ctrl #(.DIGITS(D), .WRAP(1'b0)) u_w0 (
    .clk(clk), .rst(rst), .pause_start(ps), .lap(lp), .clear(clr), .tick(tk),
    .mode_down(md), .preset(pre), .state(st_o[1]), .count(cnt_o[1]),
    .display(dsp_o[1]), .done(dn_o[1]), .wrap(wr_o[1])
  );

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int preset_value(input logic [W-1:0] p);
    int r, scale, n;
    r = 0;
    scale = 1;
    for (int i = 0; i < D; i++) begin
      n = int'(p[4*i +: 4]);
      if (n > 9) n = 9;
      r += n * scale;
      scale *= 10;
    end
    return r;
  endfunction

  // Decimal-integer reference of one clock edge, using the inputs presented before it.
  task automatic model(input int k);
    int  init;
    bit  ended;
    init = md ? preset_value(pre) : 0;
    m_done[k] = 1'b0;
    m_wrap[k] = 1'b0;
    ended = 1'b0;
    if (rst) begin
      m_st[k] = 0; m_cnt[k] = 0; m_lap[k] = 0; m_mode[k] = 1'b0;
    end else if (clr) begin
      m_st[k] = 0; m_cnt[k] = init;
    end else begin
      case (m_st[k])
        0: begin
          m_cnt[k] = init;
          if (ps && !(md && init == 0)) begin
            m_st[k] = 1; m_mode[k] = md;
          end
        end
        1, 3: begin
          if (tk) begin
            if (!m_mode[k]) begin
              if (m_cnt[k] == MAXV) begin
                if (k == 0) begin
                  m_cnt[k] = 0; m_wrap[k] = 1'b1;
                end else begin
                  m_st[k] = 4; m_done[k] = 1'b1; ended = 1'b1;
                end
              end else begin
                m_cnt[k] += 1;
              end
            end else begin
              m_cnt[k] -= 1;
              if (m_cnt[k] == 0) begin
                m_st[k] = 4; m_done[k] = 1'b1; ended = 1'b1;
              end
            end
          end
          if (!ended) begin
            if (ps) m_st[k] = 2;
            else if (lp) begin
              if (m_st[k] == 1) begin
                m_st[k] = 3; m_lap[k] = m_cnt[k];
              end else begin
                m_st[k] = 1;
              end
            end
          end
        end
        2: if (ps) m_st[k] = 1;
        default: ;
      endcase
    end
  endtask

  task automatic step();
    for (int k = 0; k < 2; k++) model(k);
    @(posedge clk);
    #1;
    rst = 1'b0; ps = 1'b0; lp = 1'b0; clr = 1'b0; tk = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tk = 1'b1;
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tk = 1'b1; ps = 1'b1;
    step();
    for (int k = 0; k < 2; k++) begin
      checks += 5;
      if (st_o[k] !== 3'd0) begin errors++; $display("FAIL reset_state dut%0d got %0d want 0", k, st_o[k]); end
      if (cnt_o[k] !== 16'h0000) begin errors++; $display("FAIL reset_count dut%0d got %h want 0000", k, cnt_o[k]); end
      if (dsp_o[k] !== 16'h0000) begin errors++; $display("FAIL reset_display dut%0d got %h want 0000", k, dsp_o[k]); end
      if (dn_o[k] !== 1'b0) begin errors++; $display("FAIL reset_done dut%0d got %b want 0", k, dn_o[k]); end
      if (wr_o[k] !== 1'b0) begin errors++; $display("FAIL reset_wrap dut%0d got %b want 0", k, wr_o[k]); end
    end
  endtask

  task automatic test_start_pause();
    ps = 1'b1; step();
    ticks(12);
    ps = 1'b1; step();
    for (int k = 0; k < 2; k++) begin
      checks += 2;
      if (st_o[k] !== 3'd2) begin errors++; $display("FAIL pause_state dut%0d got %0d want 2", k, st_o[k]); end
      if (cnt_o[k] !== 16'h0012) begin errors++; $display("FAIL pause_count dut%0d got %h want 0012", k, cnt_o[k]); end
    end
    ticks(5);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (cnt_o[k] !== 16'h0012) begin errors++; $display("FAIL stop_hold dut%0d got %h want 0012", k, cnt_o[k]); end
    end
  endtask

  task automatic test_lap();
    clr = 1'b1; step();
    ps = 1'b1; step();
    ticks(40);
    lp = 1'b1; step();
    ticks(7);
    for (int k = 0; k < 2; k++) begin
      checks += 3;
      if (st_o[k] !== 3'd3) begin errors++; $display("FAIL lap_state dut%0d got %0d want 3", k, st_o[k]); end
      if (dsp_o[k] !== 16'h0040) begin errors++; $display("FAIL lap_display dut%0d got %h want 0040", k, dsp_o[k]); end
      if (cnt_o[k] !== 16'h0047) begin errors++; $display("FAIL lap_count dut%0d got %h want 0047", k, cnt_o[k]); end
    end
    lp = 1'b1; step();
    for (int k = 0; k < 2; k++) begin
      checks += 2;
      if (st_o[k] !== 3'd1) begin errors++; $display("FAIL unlap_state dut%0d got %0d want 1", k, st_o[k]); end
      if (dsp_o[k] !== 16'h0047) begin errors++; $display("FAIL unlap_display dut%0d got %h want 0047", k, dsp_o[k]); end
    end
  endtask

  task automatic test_pause_tick();
    clr = 1'b1; step();
    ps = 1'b1; step();
    ticks(5);
    ps = 1'b1; tk = 1'b1; step();
    for (int k = 0; k < 2; k++) begin
      checks += 2;
      if (cnt_o[k] !== 16'h0006) begin errors++; $display("FAIL pt_stop_count dut%0d got %h want 0006", k, cnt_o[k]); end
      if (st_o[k] !== 3'd2) begin errors++; $display("FAIL pt_stop_state dut%0d got %0d want 2", k, st_o[k]); end
    end
    ps = 1'b1; tk = 1'b1; step();
    for (int k = 0; k < 2; k++) begin
      checks += 2;
      if (cnt_o[k] !== 16'h0006) begin errors++; $display("FAIL pt_run_count dut%0d got %h want 0006", k, cnt_o[k]); end
      if (st_o[k] !== 3'd1) begin errors++; $display("FAIL pt_run_state dut%0d got %0d want 1", k, st_o[k]); end
    end
  endtask

  task automatic test_clear_and_rst();
    clr = 1'b1; step();
    ps = 1'b1; step();
    ticks(123);
    lp = 1'b1; step();
    clr = 1'b1; tk = 1'b1; step();
    for (int k = 0; k < 2; k++) begin
      checks += 3;
      if (st_o[k] !== 3'd0) begin errors++; $display("FAIL clear_state dut%0d got %0d want 0", k, st_o[k]); end
      if (cnt_o[k] !== 16'h0000) begin errors++; $display("FAIL clear_count dut%0d got %h want 0000", k, cnt_o[k]); end
      if (dsp_o[k] !== 16'h0000) begin errors++; $display("FAIL clear_display dut%0d got %h want 0000", k, dsp_o[k]); end
    end
    ps = 1'b1; step();
    ticks(37);
    rst = 1'b1; tk = 1'b1; lp = 1'b1; step();
    for (int k = 0; k < 2; k++) begin
      checks += 3;
      if (st_o[k] !== 3'd0) begin errors++; $display("FAIL rst_mid_state dut%0d got %0d want 0", k, st_o[k]); end
      if (cnt_o[k] !== 16'h0000) begin errors++; $display("FAIL rst_mid_count dut%0d got %h want 0000", k, cnt_o[k]); end
      if (dsp_o[k] !== 16'h0000) begin errors++; $display("FAIL rst_mid_display dut%0d got %h want 0000", k, dsp_o[k]); end
    end
  endtask

  task automatic test_terminal_up();
    logic [W-1:0] exp_cnt [2];
    logic [2:0]   exp_st [2];
    clr = 1'b1; step();
    ps = 1'b1; step();
    ticks(9998);
    ticks(1);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (cnt_o[k] !== 16'h9999) begin errors++; $display("FAIL term_9999 dut%0d got %h want 9999", k, cnt_o[k]); end
    end
    ticks(1);
    exp_cnt[0] = 16'h0000; exp_cnt[1] = 16'h9999;
    exp_st[0]  = 3'd1;     exp_st[1]  = 3'd4;
    for (int k = 0; k < 2; k++) begin
      checks += 4;
      if (cnt_o[k] !== exp_cnt[k]) begin errors++; $display("FAIL term_count dut%0d got %h want %h", k, cnt_o[k], exp_cnt[k]); end
      if (st_o[k] !== exp_st[k]) begin errors++; $display("FAIL term_state dut%0d got %0d want %0d", k, st_o[k], exp_st[k]); end
      if (wr_o[k] !== (k == 0)) begin errors++; $display("FAIL term_wrap dut%0d got %b want %b", k, wr_o[k], (k == 0)); end
      if (dn_o[k] !== (k == 1)) begin errors++; $display("FAIL term_done dut%0d got %b want %b", k, dn_o[k], (k == 1)); end
    end
    ticks(1);
    exp_cnt[0] = 16'h0001;
    for (int k = 0; k < 2; k++) begin
      checks += 3;
      if (wr_o[k] !== 1'b0) begin errors++; $display("FAIL term_wrap_pulse dut%0d got %b want 0", k, wr_o[k]); end
      if (dn_o[k] !== 1'b0) begin errors++; $display("FAIL term_done_pulse dut%0d got %b want 0", k, dn_o[k]); end
      if (cnt_o[k] !== exp_cnt[k]) begin errors++; $display("FAIL term_after dut%0d got %h want %h", k, cnt_o[k], exp_cnt[k]); end
    end
  endtask

  task automatic test_down();
    logic [W-1:0] exp_seq [3];
    exp_seq[0] = 16'h0002; exp_seq[1] = 16'h0001; exp_seq[2] = 16'h0000;
    md = 1'b1; pre = 16'h0003;
    clr = 1'b1; step();
    ps = 1'b1; step();
    for (int t = 0; t < 3; t++) begin
      ticks(1);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (cnt_o[k] !== exp_seq[t]) begin errors++; $display("FAIL down_count dut%0d t%0d got %h want %h", k, t, cnt_o[k], exp_seq[t]); end
      end
    end
    for (int k = 0; k < 2; k++) begin
      checks += 2;
      if (st_o[k] !== 3'd4) begin errors++; $display("FAIL down_state dut%0d got %0d want 4", k, st_o[k]); end
      if (dn_o[k] !== 1'b1) begin errors++; $display("FAIL down_done dut%0d got %b want 1", k, dn_o[k]); end
    end
    ps = 1'b1; tk = 1'b1; step();
    for (int k = 0; k < 2; k++) begin
      checks += 3;
      if (st_o[k] !== 3'd4) begin errors++; $display("FAIL down_ignore dut%0d got %0d want 4", k, st_o[k]); end
      if (dn_o[k] !== 1'b0) begin errors++; $display("FAIL down_done_once dut%0d got %b want 0", k, dn_o[k]); end
      if (cnt_o[k] !== 16'h0000) begin errors++; $display("FAIL down_hold dut%0d got %h want 0000", k, cnt_o[k]); end
    end
    pre = 16'h0000; clr = 1'b1; step();
    ps = 1'b1; step();
    pre = 16'h00AF; step();
    for (int k = 0; k < 2; k++) begin
      checks += 2;
      if (st_o[k] !== 3'd0) begin errors++; $display("FAIL down_zero_start dut%0d got %0d want 0", k, st_o[k]); end
      if (cnt_o[k] !== 16'h0099) begin errors++; $display("FAIL down_clamp dut%0d got %h want 0099", k, cnt_o[k]); end
    end
    md = 1'b0; pre = '0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      tk  = ($urandom_range(0, 1) == 1);
      ps  = ($urandom_range(0, 99) < 8);
      lp  = ($urandom_range(0, 99) < 8);
      clr = ($urandom_range(0, 99) < 2);
      rst = ($urandom_range(0, 999) < 5);
      if ($urandom_range(0, 99) < 5) md = ~md;
      if ($urandom_range(0, 99) < 5) begin
        pre = '0;
        pre[3:0] = 4'($urandom_range(0, 15));
        pre[7:4] = 4'($urandom_range(0, 3));
        if ($urandom_range(0, 9) == 0) pre[15:8] = 8'($urandom);
      end
      step();
      for (int k = 0; k < 2; k++) begin
        checks += 5;
        if (st_o[k] !== 3'(m_st[k])) begin errors++; $display("FAIL rnd_state c%0d dut%0d got %0d want %0d", c, k, st_o[k], m_st[k]); end
        if (cnt_o[k] !== int2bcd(m_cnt[k])) begin errors++; $display("FAIL rnd_count c%0d dut%0d got %h want %h", c, k, cnt_o[k], int2bcd(m_cnt[k])); end
        if (dsp_o[k] !== int2bcd(m_st[k] == 3 ? m_lap[k] : m_cnt[k])) begin
          errors++;
          $display("FAIL rnd_display c%0d dut%0d got %h want %h", c, k, dsp_o[k], int2bcd(m_st[k] == 3 ? m_lap[k] : m_cnt[k]));
        end
        if (dn_o[k] !== m_done[k]) begin errors++; $display("FAIL rnd_done c%0d dut%0d got %b want %b", c, k, dn_o[k], m_done[k]); end
        if (wr_o[k] !== m_wrap[k]) begin errors++; $display("FAIL rnd_wrap c%0d dut%0d got %b want %b", c, k, wr_o[k], m_wrap[k]); end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_cnt[k] = 0; m_lap[k] = 0;
      m_mode[k] = 1'b0; m_done[k] = 1'b0; m_wrap[k] = 1'b0;
    end
    #2;
    test_reset();
    test_start_pause();
    test_lap();
    test_pause_tick();
    test_clear_and_rst();
    test_terminal_up();
    test_down();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
